// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: bundles the two writeback requesters and the register-file write port.
//   a_valid/a_rd/a_data -> a_ready    requester A (ALU writeback)
//   b_valid/b_rd/b_data -> b_ready    requester B (memory load)
//   reg_write/rd/data_write           registered write port toward the register file
//   pending                           per-register "write in flight" mask
//   master: requester/register-file side, slave: arbiter side
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic                 a_valid;
    logic [ADDR_W-1:0]    a_rd;
    logic [DATA_W-1:0]    a_data;
    logic                 a_ready;
    logic                 b_valid;
    logic [ADDR_W-1:0]    b_rd;
    logic [DATA_W-1:0]    b_data;
    logic                 b_ready;
    logic                 reg_write;
    logic [ADDR_W-1:0]    rd;
    logic [DATA_W-1:0]    data_write;
    logic [2**ADDR_W-1:0] pending;
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, reg_write, rd, data_write, pending
    );
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, reg_write, rd, data_write, pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: queues writebacks from two requesters and issues one register-file write per cycle.
//   clk    sole clock, rising edge
//   rst    asynchronous active-high reset
//   rf_io  slave side of regfile_write_arbiter_if (requester A/B handshakes, write port, pending mask)
//   Each requester owns a DEPTH-entry FIFO of {rd, data}; contention alternates, A wins first after reset.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave rf_io
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int NREG  = 2 ** ADDR_W;

    logic [ENT_W-1:0]  mem_q [2][DEPTH];
    logic [PW-1:0]     wp_q [2], wp_d [2], rp_q [2], rp_d [2];
    logic [CW-1:0]     cnt_q [2], cnt_d [2];
    logic              last_q, last_d, we_q, we_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        vld, rdy, push, pop, ne;
    logic [ENT_W-1:0]  din [2];
    logic              gnt, sel;
    logic [PW-1:0]     off;
    logic [NREG-1:0]   pend;

    assign vld     = {rf_io.b_valid, rf_io.a_valid};
    assign din[0]  = {rf_io.a_rd, rf_io.a_data};
    assign din[1]  = {rf_io.b_rd, rf_io.b_data};

    always_comb begin
        off  = '0;
        pend = '0;
        for (int x = 0; x < 2; x++) begin
            rdy[x]  = cnt_q[x] < CW'(DEPTH);
            push[x] = vld[x] && rdy[x];
            ne[x]   = cnt_q[x] != '0;
        end
        gnt = |ne;
        // Under contention the queue not served last wins; otherwise the lone non-empty queue.
        sel = &ne ? ~last_q : ne[1];
        for (int x = 0; x < 2; x++) begin
            pop[x]   = gnt && (sel == 1'(x));
            cnt_d[x] = cnt_q[x] + CW'(push[x]) - CW'(pop[x]);
            wp_d[x]  = wp_q[x] + PW'(push[x]);
            rp_d[x]  = rp_q[x] + PW'(pop[x]);
            // Slot i is occupied when its distance from the read pointer is below the count.
            for (int i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rp_q[x];
                if ({1'b0, off} < cnt_q[x])
                    pend[mem_q[x][i][DATA_W +: ADDR_W]] = 1'b1;
            end
        end
        if (we_q)
            pend[rd_q] = 1'b1;
        we_d             = gnt;
        last_d           = gnt ? sel : last_q;
        {rd_d, data_d}   = gnt ? mem_q[sel][rp_q[sel]] : {rd_q, data_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int x = 0; x < 2; x++) begin
                cnt_q[x] <= '0;
                wp_q[x]  <= '0;
                rp_q[x]  <= '0;
            end
            last_q <= 1'b1;
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            for (int x = 0; x < 2; x++) begin
                cnt_q[x] <= cnt_d[x];
                wp_q[x]  <= wp_d[x];
                rp_q[x]  <= rp_d[x];
            end
            last_q <= last_d;
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    // Storage needs no reset: occupancy is defined solely by the counts.
    always_ff @(posedge clk) begin
        for (int x = 0; x < 2; x++)
            if (push[x])
                mem_q[x][wp_q[x]] <= din[x];
    end

    assign rf_io.a_ready    = rdy[0];
    assign rf_io.b_ready    = rdy[1];
    assign rf_io.reg_write  = we_q;
    assign rf_io.rd         = rd_q;
    assign rf_io.data_write = data_q;
    assign rf_io.pending    = pend;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic [19:0] wlog [$];
    int          na;

    regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(4)) rf ();

    regfile_write_arbiter #(.DATA_W(16), .ADDR_W(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .rf_io (rf.slave)
    );

    always #5 clk = ~clk;

    // Record every register-file write, sampled just after the edge that launched it.
    always @(posedge clk) begin
        #1;
        if (rf.reg_write === 1'b1)
            wlog.push_back({rf.rd, rf.data_write});
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        rf.a_valid = 1'b0;
        rf.b_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        wlog.delete();
    endtask

    initial begin
        rf.a_valid = 0; rf.a_rd = 0; rf.a_data = 0;
        rf.b_valid = 0; rf.b_rd = 0; rf.b_data = 0;
        #2;
        check("rst_we", rf.reg_write, 0);
        check("rst_rd", rf.rd, 0);
        check("rst_data", rf.data_write, 0);
        check("rst_pend", rf.pending, 0);
        check("rst_ardy", rf.a_ready, 1);
        check("rst_brdy", rf.b_ready, 1);
        step();
        rst = 1'b0;

        // single write
        rf.a_valid = 1; rf.a_rd = 3; rf.a_data = 16'd12;
        step(); idle();
        check("s_pend1", rf.pending[3], 1);
        check("s_we1", rf.reg_write, 0);
        step();
        check("s_we2", rf.reg_write, 1);
        check("s_rd2", rf.rd, 3);
        check("s_data2", rf.data_write, 12);
        check("s_pend2", rf.pending[3], 1);
        step();
        check("s_we3", rf.reg_write, 0);
        check("s_pend3", rf.pending, 0);
        check("s_rdhold", rf.rd, 3);
        check("s_datahold", rf.data_write, 12);

        // contention: A first after reset, then B
        pulse_rst();
        rf.a_valid = 1; rf.a_rd = 1; rf.a_data = 16'h0011;
        rf.b_valid = 1; rf.b_rd = 2; rf.b_data = 16'h0022;
        step(); idle();
        check("c_we1", rf.reg_write, 0);
        step();
        check("c_we2", rf.reg_write, 1);
        check("c_rd2", rf.rd, 1);
        check("c_data2", rf.data_write, 16'h0011);
        step();
        check("c_we3", rf.reg_write, 1);
        check("c_rd3", rf.rd, 2);
        check("c_data3", rf.data_write, 16'h0022);
        step();
        check("c_we4", rf.reg_write, 0);
        check("c_cnt", wlog.size(), 2);

        // backpressure: an A entry stalls B for one cycle so B's queue fills
        pulse_rst();
        rf.a_valid = 1; rf.a_rd = 7; rf.a_data = 16'h7777;
        rf.b_valid = 1; rf.b_rd = 8; rf.b_data = 16'h0100;
        step();
        rf.a_valid = 0;
        check("b_rdy1", rf.b_ready, 1);
        rf.b_data = 16'h0200;
        step();
        check("b_rdy2", rf.b_ready, 0);
        rf.b_data = 16'h0300;
        step();
        check("b_rdy3", rf.b_ready, 1);
        step(); idle();
        repeat (3) step();
        check("b_cnt", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("b_w0", wlog[0], {4'd7, 16'h7777});
            check("b_w1", wlog[1], {4'd8, 16'h0100});
            check("b_w2", wlog[2], {4'd8, 16'h0200});
            check("b_w3", wlog[3], {4'd8, 16'h0300});
        end

        // fairness: both requesters keep offering for 8 cycles
        pulse_rst();
        rf.a_valid = 1; rf.a_rd = 1; rf.a_data = 16'hA0A0;
        rf.b_valid = 1; rf.b_rd = 2; rf.b_data = 16'hB0B0;
        repeat (8) step();
        idle();
        repeat (4) step();
        check("f_cnt", wlog.size(), 10);
        na = 0;
        if (wlog.size() >= 8)
            for (int k = 0; k < 8; k++) begin
                check($sformatf("f_alt%0d", k), wlog[k][19:16], (k % 2) ? 4'd2 : 4'd1);
                if (wlog[k][19:16] == 4'd1)
                    na++;
            end
        check("f_na", na, 4);

        // same destination register from both requesters
        pulse_rst();
        rf.a_valid = 1; rf.a_rd = 5; rf.a_data = 16'hAAAA;
        rf.b_valid = 1; rf.b_rd = 5; rf.b_data = 16'hBBBB;
        step(); idle();
        check("d_pend1", rf.pending[5], 1);
        step();
        check("d_pend2", rf.pending[5], 1);
        check("d_data2", rf.data_write, 16'hAAAA);
        step();
        check("d_pend3", rf.pending[5], 1);
        check("d_data3", rf.data_write, 16'hBBBB);
        step();
        check("d_pend4", rf.pending[5], 0);
        check("d_cnt", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("d_w0", wlog[0], {4'd5, 16'hAAAA});
            check("d_w1", wlog[1], {4'd5, 16'hBBBB});
        end

        // asynchronous reset mid-operation
        pulse_rst();
        rf.a_valid = 1; rf.a_rd = 10; rf.a_data = 16'h1010;
        rf.b_valid = 1; rf.b_rd = 11; rf.b_data = 16'h1111;
        step(); step(); idle();
        check("r_busy", rf.reg_write, 1);
        #1 rst = 1'b1;
        #1;
        check("r_we", rf.reg_write, 0);
        check("r_pend", rf.pending, 0);
        check("r_ardy", rf.a_ready, 1);
        check("r_brdy", rf.b_ready, 1);
        check("r_data", rf.data_write, 0);
        #1 rst = 1'b0;
        wlog.delete();
        repeat (4) step();
        check("r_nowr", wlog.size(), 0);
        rf.a_valid = 1; rf.a_rd = 9; rf.a_data = 16'h1234;
        step(); idle();
        step();
        check("r_we2", rf.reg_write, 1);
        check("r_rd2", rf.rd, 9);
        check("r_data2", rf.data_write, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
